// File: rtl/interconn_arbiter_rr.sv
// Round-robin serial-bus arbiter with split-transaction parking and priority resume.
// Optional watchdog release when ARB_TIMEOUT_EN is defined.
module interconn_arbiter_rr #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned MW             = $clog2(NUM_MASTERS),
  parameter int unsigned SW             = $clog2(NUM_SLAVES),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        MASTER_CLK,
  input  logic                        MASTER_RST,
  input  logic [NUM_MASTERS-1:0]      M_RQST,
  input  logic [NUM_MASTERS*SW-1:0]   M_SLAVE_SEL,
  input  logic                        TX_DONE,
  input  logic [NUM_SLAVES-1:0]       S_SPLIT_EN,
  output logic [NUM_MASTERS-1:0]      M_GRANT,
  output logic [MW-1:0]               BUS_GRANT,
  output logic [SW-1:0]               SLAVE_SELECT,
  output logic                        BUS_BUSY,
  output logic                        ARB_BUSY,
  output logic [NUM_MASTERS-1:0]      SPLIT_PENDING,
  output logic                        TIMEOUT
);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          bus_grant_q, bus_grant_d;
  logic [SW-1:0]          slave_sel_q, slave_sel_d;
  logic                   bus_busy_q, bus_busy_d;
  logic                   arb_busy_q;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] split_pending_q, split_pending_d;
  logic [SW-1:0]          split_slave_q [NUM_MASTERS];
  logic [SW-1:0]          split_slave_d [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] eligible, resumable;
  logic                   pick_vld, pick_resume;
  logic [MW-1:0]          pick_idx;
  logic                   timeout_hit;

  always_comb begin
    logic [SW-1:0] sel_v;
    logic          held_v;
    eligible  = '0;
    resumable = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      sel_v  = M_SLAVE_SEL[i*SW +: SW];
      held_v = 1'b0;
      // A slave parked by another master's split is off limits until that master resumes.
      for (int j = 0; j < int'(NUM_MASTERS); j++) begin
        if (j != i && split_pending_q[j] && split_slave_q[j] == sel_v) held_v = 1'b1;
      end
      eligible[i]  = M_RQST[i] && !split_pending_q[i] && !held_v &&
                     (32'(sel_v) < NUM_SLAVES);
      resumable[i] = split_pending_q[i] && M_RQST[i] && !S_SPLIT_EN[split_slave_q[i]];
    end
  end

  always_comb begin
    int unsigned idx;
    pick_vld    = 1'b0;
    pick_resume = 1'b0;
    pick_idx    = '0;
    idx         = 0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (!pick_vld && resumable[i]) begin
        pick_vld    = 1'b1;
        pick_resume = 1'b1;
        pick_idx    = MW'(i);
      end
    end
    for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
      idx = (32'(ptr_q) + 32'(k)) % NUM_MASTERS;
      if (!pick_vld && eligible[idx]) begin
        pick_vld = 1'b1;
        pick_idx = MW'(idx);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == StBusy) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge MASTER_CLK) begin
    if (!MASTER_RST) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign TIMEOUT     = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    bus_grant_d     = bus_grant_q;
    slave_sel_d     = slave_sel_q;
    bus_busy_d      = bus_busy_q;
    ptr_d           = ptr_q;
    split_pending_d = split_pending_q;
    split_slave_d   = split_slave_q;
`ifdef ARB_TIMEOUT_EN
    timeout_d       = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d                   = StGrant;
          grant_d                   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
          bus_grant_d               = pick_idx;
          slave_sel_d               = pick_resume ? split_slave_q[pick_idx]
                                                  : M_SLAVE_SEL[pick_idx*SW +: SW];
          bus_busy_d                = 1'b1;
          ptr_d                     = pick_idx;
          split_pending_d[pick_idx] = 1'b0;
        end
      end
      StGrant: begin
        state_d = StBusy;
      end
      StBusy: begin
        if (TX_DONE) begin
          state_d = StIdle;
        end else if (S_SPLIT_EN[slave_sel_q]) begin
          state_d                      = StIdle;
          split_pending_d[bus_grant_q] = 1'b1;
          split_slave_d[bus_grant_q]   = slave_sel_q;
`ifdef ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
`endif
        end else if (!M_RQST[bus_grant_q]) begin
          state_d = StIdle;
        end
        if (state_d == StIdle) begin
          grant_d     = '0;
          bus_grant_d = '0;
          slave_sel_d = '0;
          bus_busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MASTER_CLK) begin
    if (!MASTER_RST) begin
      state_q         <= StIdle;
      grant_q         <= '0;
      bus_grant_q     <= '0;
      slave_sel_q     <= '0;
      bus_busy_q      <= 1'b0;
      arb_busy_q      <= 1'b0;
      ptr_q           <= MW'(NUM_MASTERS - 1);
      split_pending_q <= '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) split_slave_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      bus_grant_q     <= bus_grant_d;
      slave_sel_q     <= slave_sel_d;
      bus_busy_q      <= bus_busy_d;
      arb_busy_q      <= (state_d != StIdle);
      ptr_q           <= ptr_d;
      split_pending_q <= split_pending_d;
      split_slave_q   <= split_slave_d;
    end
  end

  assign M_GRANT       = grant_q;
  assign BUS_GRANT     = bus_grant_q;
  assign SLAVE_SELECT  = slave_sel_q;
  assign BUS_BUSY      = bus_busy_q;
  assign ARB_BUSY      = arb_busy_q;
  assign SPLIT_PENDING = split_pending_q;

endmodule

// File: tb/tb_interconn_arbiter_rr.sv
// Directed bench for interconn_arbiter_rr: grant latency, round-robin, split/resume,
// precedence, abort, reset and (with ARB_TIMEOUT_EN) watchdog release.
module tb_interconn_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] m_rqst;
  logic [7:0] m_slave_sel;
  logic       tx_done;
  logic [3:0] s_split_en;
  logic [3:0] m_grant;
  logic [1:0] bus_grant;
  logic [1:0] slave_select;
  logic       bus_busy;
  logic       arb_busy;
  logic [3:0] split_pending;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  interconn_arbiter_rr #(
    .NUM_MASTERS   (4),
    .NUM_SLAVES    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .MASTER_CLK   (clk),
    .MASTER_RST   (rst_n),
    .M_RQST       (m_rqst),
    .M_SLAVE_SEL  (m_slave_sel),
    .TX_DONE      (tx_done),
    .S_SPLIT_EN   (s_split_en),
    .M_GRANT      (m_grant),
    .BUS_GRANT    (bus_grant),
    .SLAVE_SELECT (slave_select),
    .BUS_BUSY     (bus_busy),
    .ARB_BUSY     (arb_busy),
    .SPLIT_PENDING(split_pending),
    .TIMEOUT      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    m_rqst      = '0;
    m_slave_sel = '0;
    tx_done     = 1'b0;
    s_split_en  = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_grant, bus_grant, slave_select, bus_busy, arb_busy, split_pending, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b bg=%0d ss=%0d bb=%b ab=%b sp=%b to=%b want all 0",
               m_grant, bus_grant, slave_select, bus_busy, arb_busy, split_pending, timeout);
    end
    // TX_DONE and split in IDLE must not start anything
    tx_done    = 1'b1;
    s_split_en = 4'b1111;
    tick();
    tx_done    = 1'b0;
    s_split_en = '0;
    checks++;
    if (arb_busy !== 1'b0 || split_pending !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ignore got ab=%b sp=%b want ab=0 sp=0000", arb_busy, split_pending);
    end
  endtask

  task automatic test_basic();
    do_reset();
    m_rqst      = 4'b0001;
    m_slave_sel = 8'h02;
    tick();
    checks++;
    if (m_grant !== 4'b0001 || bus_grant !== 2'd0 || slave_select !== 2'd2 ||
        bus_busy !== 1'b1 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant got grant=%b bg=%0d ss=%0d bb=%b ab=%b want 0001 0 2 1 1",
               m_grant, bus_grant, slave_select, bus_busy, arb_busy);
    end
    tick();
    checks++;
    if (m_grant !== 4'b0001 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold got grant=%b ab=%b want 0001 1", m_grant, arb_busy);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    m_rqst  = '0;
    checks++;
    if (m_grant !== 4'b0000 || bus_busy !== 1'b0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got grant=%b bb=%b ab=%b want 0000 0 0",
               m_grant, bus_busy, arb_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    m_rqst      = 4'b1111;
    m_slave_sel = 8'h00;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      tick();
      checks++;
      if (m_grant !== exp || bus_grant !== 2'(k % 4)) begin
        errors++;
        $display("FAIL rr_grant[%0d] got grant=%b bg=%0d want %b %0d",
                 k, m_grant, bus_grant, exp, k % 4);
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (k == 4) m_rqst = '0;
      checks++;
      if (m_grant !== 4'b0000 || arb_busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_turnaround[%0d] got grant=%b ab=%b want 0000 0", k, m_grant, arb_busy);
      end
    end
  endtask

  task automatic test_split();
    do_reset();
    m_rqst      = 4'b0010;
    m_slave_sel = 8'b00_00_11_00;
    tick();
    checks++;
    if (m_grant !== 4'b0010 || slave_select !== 2'd3) begin
      errors++;
      $display("FAIL split_first_grant got grant=%b ss=%0d want 0010 3", m_grant, slave_select);
    end
    tick();
    s_split_en = 4'b1000;
    tick();
    checks++;
    if (split_pending !== 4'b0010 || m_grant !== 4'b0000 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL split_park got sp=%b grant=%b bb=%b want 0010 0000 0",
               split_pending, m_grant, bus_busy);
    end
    // m2 targets the parked slave 3, m0 targets slave 1
    m_rqst      = 4'b0111;
    m_slave_sel = 8'b00_11_11_01;
    tick();
    checks++;
    if (m_grant !== 4'b0001 || slave_select !== 2'd1) begin
      errors++;
      $display("FAIL split_other_grant got grant=%b ss=%0d want 0001 1", m_grant, slave_select);
    end
    tick();
    s_split_en  = 4'b0000;
    tx_done     = 1'b1;
    m_slave_sel = 8'b00_11_00_01;
    tick();
    tx_done = 1'b0;
    checks++;
    if (m_grant !== 4'b0000 || split_pending !== 4'b0010) begin
      errors++;
      $display("FAIL split_still_parked got grant=%b sp=%b want 0000 0010", m_grant, split_pending);
    end
    tick();
    checks++;
    if (m_grant !== 4'b0010 || bus_grant !== 2'd1 || slave_select !== 2'd3 ||
        split_pending !== 4'b0000) begin
      errors++;
      $display("FAIL split_resume got grant=%b bg=%0d ss=%0d sp=%b want 0010 1 3 0000",
               m_grant, bus_grant, slave_select, split_pending);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    m_rqst  = '0;
  endtask

  task automatic test_precedence();
    do_reset();
    m_rqst      = 4'b0100;
    m_slave_sel = 8'b00_01_00_00;
    tick();
    s_split_en = 4'b0010;
    tick();
    s_split_en = 4'b0000;
    checks++;
    if (m_grant !== 4'b0100 || arb_busy !== 1'b1 || split_pending !== 4'b0000) begin
      errors++;
      $display("FAIL split_in_grant got grant=%b ab=%b sp=%b want 0100 1 0000",
               m_grant, arb_busy, split_pending);
    end
    tx_done    = 1'b1;
    s_split_en = 4'b0010;
    tick();
    tx_done    = 1'b0;
    s_split_en = 4'b0000;
    m_rqst     = '0;
    checks++;
    if (split_pending !== 4'b0000 || m_grant !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_beats_split got sp=%b grant=%b ab=%b want 0000 0000 0",
               split_pending, m_grant, arb_busy);
    end
  endtask

  task automatic test_abort();
    do_reset();
    m_rqst      = 4'b1000;
    m_slave_sel = 8'b10_00_00_00;
    tick();
    tick();
    m_rqst = 4'b0000;
    tick();
    checks++;
    if (m_grant !== 4'b0000 || bus_busy !== 1'b0 || arb_busy !== 1'b0 ||
        split_pending !== 4'b0000) begin
      errors++;
      $display("FAIL abort_release got grant=%b bb=%b ab=%b sp=%b want 0000 0 0 0000",
               m_grant, bus_busy, arb_busy, split_pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_rqst      = 4'b0100;
    m_slave_sel = 8'b00_10_00_00;
    tick();
    tick();
    s_split_en = 4'b0100;
    tick();
    m_rqst = 4'b0001;
    tick();
    tick();
    checks++;
    if (split_pending !== 4'b0100 || m_grant !== 4'b0001 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup got sp=%b grant=%b ab=%b want 0100 0001 1",
               split_pending, m_grant, arb_busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({m_grant, bus_grant, slave_select, bus_busy, arb_busy, split_pending, timeout} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got grant=%b bg=%0d ss=%0d bb=%b ab=%b sp=%b want all 0",
               m_grant, bus_grant, slave_select, bus_busy, arb_busy, split_pending);
    end
    s_split_en  = 4'b0000;
    m_rqst      = 4'b1111;
    m_slave_sel = 8'h00;
    tick();
    checks++;
    if (m_grant !== 4'b0001 || bus_grant !== 2'd0) begin
      errors++;
      $display("FAIL midreset_next got grant=%b bg=%0d want 0001 0", m_grant, bus_grant);
    end
    m_rqst = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m_rqst      = 4'b0001;
    m_slave_sel = 8'h00;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (m_grant !== 4'b0001 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold[%0d] got grant=%b to=%b want 0001 0", k, m_grant, timeout);
      end
    end
    m_rqst = '0;
    tick();
    checks++;
    if (m_grant !== 4'b0000 || timeout !== 1'b1 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got grant=%b to=%b ab=%b want 0000 1 0",
               m_grant, timeout, arb_busy);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got to=%b want 0", timeout);
    end
`else
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (m_grant !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog got grant=%b to=%b want 0001 0", m_grant, timeout);
    end
    m_rqst = '0;
    tick();
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    m_rqst      = '0;
    m_slave_sel = '0;
    tx_done     = 1'b0;
    s_split_en  = '0;
    tick();
    test_reset();
    test_basic();
    test_round_robin();
    test_split();
    test_precedence();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interconn_arbiter_rr.md
Name: interconn_arbiter_rr

Overview:
Parametrised successor to the fixed 2-master/3-slave serial-bus arbiter. It grants the shared serial bus to one of NUM_MASTERS requesters using round-robin order, and drives the master index and slave index to the bus multiplexer. It supports split transactions: a slave can park the granted master and release the bus, and that master is resumed with priority once the slave is ready.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
NUM_SLAVES, 4, number of slaves (2..8)
MW, $clog2(NUM_MASTERS), master index width (derived)
SW, $clog2(NUM_SLAVES), slave index width (derived)
TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
MASTER_CLK  in  1  system clock; all logic on the rising edge
MASTER_RST  in  1  synchronous, active-low reset
M_RQST  in  NUM_MASTERS  per-master bus request
M_SLAVE_SEL  in  NUM_MASTERS*SW  per-master target slave index; master i occupies bits [i*SW +: SW]
TX_DONE  in  1  single-cycle pulse from the active transaction marking its end
S_SPLIT_EN  in  NUM_SLAVES  per-slave split request, level-sensitive
M_GRANT  out  NUM_MASTERS  one-hot grant
BUS_GRANT  out  MW  index of the granted master, to the multiplexer
SLAVE_SELECT  out  SW  slave index latched at grant time, to the multiplexer
BUS_BUSY  out  1  a grant is active
ARB_BUSY  out  1  FSM is not in IDLE
SPLIT_PENDING  out  NUM_MASTERS  master is parked in a split
TIMEOUT  out  1  one-cycle pulse on a watchdog release

Behaviour:
- Reset (MASTER_RST==0 at an edge): FSM goes to IDLE.
  - M_GRANT=0, BUS_GRANT=0, SLAVE_SELECT=0.
  - BUS_BUSY=0, ARB_BUSY=0, SPLIT_PENDING=0, TIMEOUT=0.
  - Round-robin pointer is set to NUM_MASTERS-1, so master 0 wins first.
  - Reset mid-transaction or mid-split discards all state, including split records.
- All outputs are registered.
- Eligibility: master i is eligible when all of the following hold:
  - M_RQST[i]=1;
  - SPLIT_PENDING[i]=0;
  - its target slave is not held by another master's split record.
- Resumable: master i is resumable when all of the following hold:
  - SPLIT_PENDING[i]=1;
  - M_RQST[i]=1;
  - S_SPLIT_EN of its recorded slave is 0.
- FSM states: IDLE, GRANT, BUSY.
- IDLE:
  - If any master is resumable, choose the lowest-index resumable master.
  - Otherwise, if any master is eligible, choose the first eligible master searching pointer+1 upward with wrap-around.
  - On a choice, go to GRANT. The grant registers appear on the next edge, giving a 1-cycle request-to-grant latency.
  - SLAVE_SELECT latches the chosen master's M_SLAVE_SEL; for a resumed master it latches the recorded split slave.
  - The chosen master's SPLIT_PENDING is cleared and the pointer is updated to the chosen index.
- GRANT: one cycle with M_GRANT, BUS_GRANT and BUS_BUSY asserted, then go to BUSY. ARB_BUSY=1 in GRANT and BUSY.
- BUSY: the grant is held and the first matching condition applies:
  1. TX_DONE=1: release the grant and go to IDLE.
  2. S_SPLIT_EN[SLAVE_SELECT]=1:
     - set SPLIT_PENDING[granted master];
     - record SLAVE_SELECT as that master's split slave;
     - release the grant and go to IDLE.
  3. M_RQST[granted]=0: abort, release the grant and go to IDLE.
- Release: M_GRANT=0 and BUS_BUSY=0 from the next edge. IDLE needs at least one cycle before the next grant, so there is a 1-cycle bus turnaround.
- Simultaneous events:
  - TX_DONE together with a split: TX_DONE wins and no split is recorded.
  - Split raised during GRANT: ignored until BUSY.
- A request that drops while the master is parked leaves SPLIT_PENDING set. The master is resumed only when it requests again.
- TX_DONE or S_SPLIT_EN received in IDLE is ignored.
- An out-of-range M_SLAVE_SEL (≥ NUM_SLAVES) makes that master ineligible.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a counter clears on entering GRANT and increments in BUSY. When it reaches TIMEOUT_CYCLES-1, the arbiter releases the grant as an abort, pulses TIMEOUT for one cycle, and goes to IDLE. A split or TX_DONE arriving in the same cycle takes precedence over the timeout.
- Undefined: no counter is built and TIMEOUT is tied to 0.

Test Plan:
- Reset then M_RQST=4'b0001 with M_SLAVE_SEL[0]=2 → M_GRANT=0001, BUS_GRANT=0, SLAVE_SELECT=2 one cycle after the request; TX_DONE → M_GRANT=0000 on the next edge.
- M_RQST=4'b1111 held, with a TX_DONE pulse each BUSY cycle → grant order 0,1,2,3,0 and exactly one IDLE cycle between grants.
- Master 1 granted to slave 3, S_SPLIT_EN[3]=1 → SPLIT_PENDING=0010 and the bus is released. Master 2 requests slave 3 and is not granted, while master 0 to slave 1 is granted. After S_SPLIT_EN[3]=0 and master 0 completes, master 1 is granted with SLAVE_SELECT=3 ahead of the round-robin order.
- TX_DONE and S_SPLIT_EN asserted in the same BUSY cycle → SPLIT_PENDING stays 0 and the arbiter returns to IDLE.
- MASTER_RST=0 for one edge while in BUSY with SPLIT_PENDING=0100 → all outputs 0 on the next edge, and the next grant goes to master 0.
- With ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, granted with no TX_DONE → the grant drops after 8 BUSY cycles and TIMEOUT pulses high for 1 cycle.
